// File: rtl/core_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// illegal-opcode and memory-timeout traps, and a retired-instruction counter.
module core_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic        br_taken,
   output logic        imem_req,
   input  logic        imem_ack,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        alu_src_a,
   output logic        alu_src_b,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        halt,
   output logic        illegal,
   output logic        bus_err,
   output logic [2:0]  state,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic [31:0] instret_q, instret_d;
   logic        illegal_q, illegal_d;
   logic        bus_err_q, bus_err_d;

   logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_legal;

   always_comb begin
      is_r     = (opcode == OP_R);
      is_i     = (opcode == OP_I);
      is_ld    = (opcode == OP_LD);
      is_st    = (opcode == OP_ST);
      is_br    = (opcode == OP_BR);
      is_jal   = (opcode == OP_JAL);
      is_jalr  = (opcode == OP_JALR);
      is_lui   = (opcode == OP_LUI);
      is_auipc = (opcode == OP_AUIPC);
      is_legal = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      instret_d = instret_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'b00;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = 2'b00;
      halt      = 1'b0;

      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end else if (wait_q == WAIT_MAX) begin
               state_d   = S_TRAP;
               bus_err_d = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE: begin
            if (is_legal) begin
               state_d = S_EXEC;
            end else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_EXEC: begin
            alu_src_a = is_auipc;
            alu_src_b = is_i | is_ld | is_st | is_jalr | is_auipc;
            if (is_ld || is_st) begin
               state_d = S_MEM;
               wait_d  = 8'd0;
            end else if (is_br) begin
               pc_we     = 1'b1;
               pc_sel    = br_taken ? 2'b01 : 2'b00;
               instret_d = instret_q + 32'd1;
               state_d   = S_FETCH;
               wait_d    = 8'd0;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            dmem_req  = 1'b1;
            dmem_we   = is_st;
            alu_src_b = 1'b1;
            if (dmem_ack) begin
               if (is_st) begin
                  pc_we     = 1'b1;
                  instret_d = instret_q + 32'd1;
                  state_d   = S_FETCH;
                  wait_d    = 8'd0;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_q == WAIT_MAX) begin
               state_d   = S_TRAP;
               bus_err_d = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_WB: begin
            rf_we     = 1'b1;
            wb_sel    = is_ld ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : is_lui ? 2'b11 : 2'b00;
            pc_we     = 1'b1;
            pc_sel    = is_jal ? 2'b10 : is_jalr ? 2'b11 : 2'b00;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
            wait_d    = 8'd0;
         end
         S_TRAP: begin
            halt = 1'b1;
         end
         default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
         end
      endcase

      // Reset masks every strobe combinationally so a pending request drops at once.
      if (rst) begin
         imem_req  = 1'b0;
         dmem_req  = 1'b0;
         dmem_we   = 1'b0;
         ir_we     = 1'b0;
         pc_we     = 1'b0;
         pc_sel    = 2'b00;
         alu_src_a = 1'b0;
         alu_src_b = 1'b0;
         rf_we     = 1'b0;
         wb_sel    = 2'b00;
         halt      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         wait_q    <= 8'd0;
         instret_q <= 32'd0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         instret_q <= instret_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign state   = state_q;
   assign instret = instret_q;
   assign illegal = illegal_q;
   assign bus_err = bus_err_q;

endmodule
